// File: rtl/posit_shift_pkg.sv
// Shared constants and the level-to-rank mapping for the posit shift pipeline.
package posit_shift_pkg;

  localparam logic SHIFT_RIGHT = 1'b0;
  localparam logic SHIFT_LEFT  = 1'b1;

  // Register rank that holds mux level lvl when levels are spread over stages ranks.
  function automatic int rank_of(input int lvl, input int stages, input int levels);
    return (lvl * stages) / levels;
  endfunction

endpackage

// File: rtl/posit_shift_level.sv
// One barrel-shifter mux level: shifts by the constant SH when enabled.
// Sticky accumulation is present only when POSIT_SHIFT_STICKY_EN is defined.
module posit_shift_level
  import posit_shift_pkg::*;
#(
  parameter int N  = 16,
  parameter int SH = 1
) (
  input  logic [N-1:0] data_i,
  input  logic         dir,
  input  logic         fill,
  input  logic         en,
  input  logic         sticky_i,
  output logic [N-1:0] data_o,
  output logic         sticky_o
);

  localparam logic [N-1:0] ONES      = '1;
  // Both masks saturate correctly when SH >= N (all bits discarded / all fill).
  localparam logic [N-1:0] LOW_MASK  = ~(ONES << SH);
  localparam logic [N-1:0] FILL_MASK = ~(ONES >> SH);

  always_comb begin
    data_o = data_i;
    if (en) begin
      if (dir == SHIFT_LEFT) data_o = data_i << SH;
      else                   data_o = (data_i >> SH) | (fill ? FILL_MASK : '0);
    end
  end

`ifdef POSIT_SHIFT_STICKY_EN
  assign sticky_o = sticky_i | (en & (dir == SHIFT_RIGHT) & (|(data_i & LOW_MASK)));
`else
  assign sticky_o = sticky_i;
`endif

endmodule

// File: rtl/posit_shift_pipe.sv
// Pipelined barrel shifter with valid/ready flow control and optional sticky output.
// Optional feature: define POSIT_SHIFT_STICKY_EN to carry a right-shift sticky flag.
module posit_shift_pipe
  import posit_shift_pkg::*;
#(
  parameter int N      = 16,
  parameter int S      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_amt,
  input  logic         in_dir,
  input  logic         in_arith,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sticky
);

  logic [N-1:0]      rin_d   [STAGES];
  logic [S-1:0]      rin_amt [STAGES];
  logic [STAGES-1:0] rin_dir, rin_arith, rin_fill;
  logic [N-1:0]      rout_d  [STAGES];
  logic [N-1:0]      data_p  [STAGES];
  logic [S-1:0]      amt_p   [STAGES];
  logic [STAGES-1:0] dir_p, arith_p, vld_p, adv;
  logic [STAGES:0]   vld_chain;
  logic [N-1:0]      lvl_d   [S];
  logic [S-1:0]      lvl_stk;
  logic              pipe_unused;
`ifdef POSIT_SHIFT_STICKY_EN
  logic [STAGES-1:0] rin_stk, rout_stk, stk_p;
`endif

  // A rank moves when it is empty or the rank after it moves.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~vld_p[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = ~vld_p[k] | adv[k+1];
  end

  assign vld_chain = {vld_p, in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p <= '0;
    else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) vld_p[k] <= vld_chain[k];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_p[STAGES-1];
  assign out_data  = data_p[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_rank
    logic [N-1:0] d_q;
    logic [S-1:0] a_q;
    logic         dr_q, ar_q;

    if (k == 0) begin : g_head
      assign rin_d[k]     = in_data;
      assign rin_amt[k]   = in_amt;
      assign rin_dir[k]   = in_dir;
      assign rin_arith[k] = in_arith;
`ifdef POSIT_SHIFT_STICKY_EN
      assign rin_stk[k]   = 1'b0;
`endif
    end else begin : g_link
      assign rin_d[k]     = data_p[k-1];
      assign rin_amt[k]   = amt_p[k-1];
      assign rin_dir[k]   = dir_p[k-1];
      assign rin_arith[k] = arith_p[k-1];
`ifdef POSIT_SHIFT_STICKY_EN
      assign rin_stk[k]   = stk_p[k-1];
`endif
    end

    // Arithmetic right shifts keep the MSB, so the rank input MSB is the sign for every level.
    assign rin_fill[k] = (rin_dir[k] == SHIFT_RIGHT) & rin_arith[k] & rin_d[k][N-1];

    // ---- rank k register boundary ----
    always_ff @(posedge clk) begin
      if (adv[k]) begin
        a_q  <= rin_amt[k];
        dr_q <= rin_dir[k];
        ar_q <= rin_arith[k];
      end
    end

    if (k == STAGES - 1) begin : g_out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       d_q <= '0;
        else if (adv[k])  d_q <= rout_d[k];
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (adv[k]) d_q <= rout_d[k];
      end
    end

`ifdef POSIT_SHIFT_STICKY_EN
    logic s_q;
    if (k == STAGES - 1) begin : g_stk_out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       s_q <= 1'b0;
        else if (adv[k])  s_q <= rout_stk[k];
      end
    end else begin : g_stk_mid
      always_ff @(posedge clk) begin
        if (adv[k]) s_q <= rout_stk[k];
      end
    end
    assign stk_p[k] = s_q;
`endif

    assign data_p[k]  = d_q;
    assign amt_p[k]   = a_q;
    assign dir_p[k]   = dr_q;
    assign arith_p[k] = ar_q;
  end

  for (genvar i = 0; i < S; i++) begin : g_lvl
    localparam int R     = rank_of(i, STAGES, S);
    localparam bit FIRST = (i == 0) || (rank_of(i - 1, STAGES, S) != R);
    localparam bit LAST  = (i == S - 1) || (rank_of(i + 1, STAGES, S) != R);
    logic [N-1:0] d_in;
    logic         s_in;

    if (FIRST) begin : g_from_rank
      assign d_in = rin_d[R];
`ifdef POSIT_SHIFT_STICKY_EN
      assign s_in = rin_stk[R];
`else
      assign s_in = 1'b0;
`endif
    end else begin : g_from_lvl
      assign d_in = lvl_d[i-1];
`ifdef POSIT_SHIFT_STICKY_EN
      assign s_in = lvl_stk[i-1];
`else
      assign s_in = 1'b0;
`endif
    end

    posit_shift_level #(
      .N  (N),
      .SH (1 << i)
    ) u_lvl (
      .data_i   (d_in),
      .dir      (rin_dir[R]),
      .fill     (rin_fill[R]),
      .en       (rin_amt[R][i]),
      .sticky_i (s_in),
      .data_o   (lvl_d[i]),
      .sticky_o (lvl_stk[i])
    );

    if (LAST) begin : g_tail
      assign rout_d[R] = lvl_d[i];
`ifdef POSIT_SHIFT_STICKY_EN
      assign rout_stk[R] = lvl_stk[i];
`endif
    end
  end

`ifdef POSIT_SHIFT_STICKY_EN
  assign out_sticky  = stk_p[STAGES-1];
  assign pipe_unused = ^{amt_p[STAGES-1], dir_p[STAGES-1], arith_p[STAGES-1]};
`else
  assign out_sticky  = 1'b0;
  assign pipe_unused = ^{amt_p[STAGES-1], dir_p[STAGES-1], arith_p[STAGES-1], lvl_stk};
`endif

endmodule
